// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM stage of the five-stage MIPS pipeline. Registers the
//               EX->MEM bus under stall control, holds the synchronous
//               data-SRAM read word while MEM is frozen, and extracts plus
//               sign/zero-extends byte, halfword and word loads.
//
// Ports       : clk              core clock, rising edge
//               rst              asynchronous active-high reset
//               stall[5:0]       stall vector; [3] EX/MEM reg, [4] MEM/WB reg
//               ex_to_mem_bus    {readen,pc,ram_en,ram_wen,sel_rf_res,
//                                 rf_we,rf_waddr,ex_result}
//               data_sram_rdata  SRAM read word for the load now in MEM
//               mem_to_wb_bus    {pc,rf_we,rf_waddr,rf_wdata}
//               mem_to_id        {rf_we,rf_waddr,rf_wdata} bypass to ID
//               mem_ale          misaligned-load flag
//
// Options     : MEM_MISALIGN_CHECK_EN  when defined, flags misaligned lw/lh/lhu
//                                      on mem_ale and suppresses their rf_we.
//                                      When undefined, mem_ale is tied 0.
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int EX_TO_MEM_WD = 80,
    parameter int MEM_TO_WB_WD = 70
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id,
    output logic                    mem_ale
);

    // Stall vector polarity: 1 freezes the stage.
    localparam logic c_STOP = 1'b1;

    // readen encodings
    localparam logic [3:0] c_LD_LW  = 4'b1111;
    localparam logic [3:0] c_LD_LB  = 4'b0001;
    localparam logic [3:0] c_LD_LBU = 4'b0010;
    localparam logic [3:0] c_LD_LH  = 4'b0011;
    localparam logic [3:0] c_LD_LHU = 4'b0100;

    // Read-data hold buffer states
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HELD = 1'b1;

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    logic [EX_TO_MEM_WD-1:0] r_ex_to_mem_bus;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_to_mem_bus <= '0;
        end else if (stall[3] == c_STOP && stall[4] != c_STOP) begin
            // EX frozen but WB advancing: inject a bubble
            r_ex_to_mem_bus <= '0;
        end else if (stall[3] != c_STOP) begin
            r_ex_to_mem_bus <= ex_to_mem_bus;
        end
    end

    logic [3:0]  w_readen;
    logic [31:0] w_pc;
    logic        w_ram_en;
    logic [3:0]  w_ram_wen;
    logic        w_sel_rf_res;
    logic        w_rf_we_raw;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_ex_result;

    assign w_readen     = r_ex_to_mem_bus[79:76];
    assign w_pc         = r_ex_to_mem_bus[75:44];
    assign w_ram_en     = r_ex_to_mem_bus[43];
    assign w_ram_wen    = r_ex_to_mem_bus[42:39];
    assign w_sel_rf_res = r_ex_to_mem_bus[38];
    assign w_rf_we_raw  = r_ex_to_mem_bus[37];
    assign w_rf_waddr   = r_ex_to_mem_bus[36:32];
    assign w_ex_result  = r_ex_to_mem_bus[31:0];

    // Store-side and unrelated stall bits are consumed elsewhere in the core.
    logic w_unused_bits;
    assign w_unused_bits = ^{w_ram_en, w_ram_wen, stall[5], stall[2:0]};

    logic w_is_load;
    always_comb begin
        w_is_load = 1'b0;
        case (w_readen)
            c_LD_LW, c_LD_LB, c_LD_LBU, c_LD_LH, c_LD_LHU: w_is_load = 1'b1;
            default:                                       w_is_load = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Read-data hold buffer. The SRAM output is only guaranteed for the
    // cycle after the address was issued, so when MEM freezes with a load
    // in it the word is captured once and replayed until MEM advances.
    // ------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic        w_buf_load;
    logic [31:0] r_rdata_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_buf_load   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_is_load && stall[4] == c_STOP) begin
                    w_state_next = c_ST_HELD;
                    w_buf_load   = 1'b1;
                end
            end
            c_ST_HELD: begin
                if (stall[4] != c_STOP) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_buf <= '0;
        end else if (w_buf_load) begin
            r_rdata_buf <= data_sram_rdata;
        end
    end

    logic [31:0] w_word;
    assign w_word = (r_state == c_ST_HELD) ? r_rdata_buf : data_sram_rdata;

    // ------------------------------------------------------------------
    // Lane extraction and extension
    // ------------------------------------------------------------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = w_word[7:0];
        case (w_ex_result[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    assign w_half = w_ex_result[1] ? w_word[31:16] : w_word[15:0];

    logic [31:0] w_load_val;
    always_comb begin
        w_load_val = w_ex_result;
        case (w_readen)
            c_LD_LW:  w_load_val = w_word;
            c_LD_LB:  w_load_val = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU: w_load_val = {24'd0, w_byte};
            c_LD_LH:  w_load_val = {{16{w_half[15]}}, w_half};
            c_LD_LHU: w_load_val = {16'd0, w_half};
            default:  w_load_val = w_ex_result;
        endcase
    end

    logic [31:0] w_rf_wdata;
    assign w_rf_wdata = w_sel_rf_res ? w_load_val : w_ex_result;

    // ------------------------------------------------------------------
    // Misaligned-load detection
    // ------------------------------------------------------------------
    logic w_mem_ale;
`ifdef MEM_MISALIGN_CHECK_EN
    assign w_mem_ale = ((w_readen == c_LD_LW) && (w_ex_result[1:0] != 2'b00)) ||
                       (((w_readen == c_LD_LH) || (w_readen == c_LD_LHU)) &&
                        w_ex_result[0]);
`else
    assign w_mem_ale = 1'b0;
`endif

    // A faulting load must not write back or forward.
    logic w_rf_we;
    assign w_rf_we = w_rf_we_raw & ~w_mem_ale;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
    assign mem_to_id     = {w_rf_we, w_rf_waddr, w_rf_wdata};
    assign mem_ale       = w_mem_ale;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. A directed driver pushes
//               hand-computed expectations into a queue tagged with the cycle
//               they apply to; a negedge monitor pops and compares them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [79:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id;
    logic        mem_ale;

    mem_stage #(
        .EX_TO_MEM_WD(80),
        .MEM_TO_WB_WD(70)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ex_to_mem_bus  (ex_to_mem_bus),
        .data_sram_rdata(data_sram_rdata),
        .mem_to_wb_bus  (mem_to_wb_bus),
        .mem_to_id      (mem_to_id),
        .mem_ale        (mem_ale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int r_cyc = 0;
    always @(posedge clk) r_cyc <= r_cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [69:0] wb;
        logic [37:0] id;
        logic        ale;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [3:0] c_LW  = 4'b1111;
    localparam logic [3:0] c_LB  = 4'b0001;
    localparam logic [3:0] c_LBU = 4'b0010;
    localparam logic [3:0] c_LH  = 4'b0011;
    localparam logic [3:0] c_LHU = 4'b0100;
    localparam logic [3:0] c_SB  = 4'b0101;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam logic c_MIS_ALE = 1'b1;
    localparam logic c_MIS_WE  = 1'b0;
`else
    localparam logic c_MIS_ALE = 1'b0;
    localparam logic c_MIS_WE  = 1'b1;
`endif

    function automatic logic [79:0] mk(input logic [3:0] rd, input logic [31:0] pc,
                                       input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {rd, pc, 1'b0, 4'b0000, sel, we, wa, res};
    endfunction

    task automatic compare(input string nm, input logic [69:0] wb, input logic [37:0] id,
                           input logic ale);
        checks++;
        if (mem_to_wb_bus !== wb) begin
            failures++;
            $display("FAIL %s mem_to_wb_bus got=%h exp=%h", nm, mem_to_wb_bus, wb);
        end
        checks++;
        if (mem_to_id !== id) begin
            failures++;
            $display("FAIL %s mem_to_id got=%h exp=%h", nm, mem_to_id, id);
        end
        checks++;
        if (mem_ale !== ale) begin
            failures++;
            $display("FAIL %s mem_ale got=%b exp=%b", nm, mem_ale, ale);
        end
    endtask

    // Monitor: every cycle, compare all expectations due this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= r_cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc < r_cyc) begin
                checks++;
                failures++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, r_cyc);
            end else begin
                compare(e.name, e.wb, e.id, e.ale);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [31:0] pc, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input logic ale);
        exp_t e;
        e.cyc  = r_cyc;
        e.name = nm;
        e.wb   = {pc, we, wa, wd};
        e.id   = {we, wa, wd};
        e.ale  = ale;
        sb_q.push_back(e);
    endtask

    // One cycle: present this cycle's SRAM word, queue what MEM must show,
    // then set up EX and stall for the next edge.
    task automatic step(input logic [31:0] rd, input string nm, input logic [31:0] pc,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ale, input logic [79:0] nbus, input logic [5:0] nstall);
        tick();
        data_sram_rdata = rd;
        push(nm, pc, we, wa, wd, ale);
        ex_to_mem_bus = nbus;
        stall         = nstall;
    endtask

    task automatic async_reset_pulse(input string nm);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        compare(nm, 70'd0, 38'd0, 1'b0);
        rst = 1'b0;
    endtask

    logic [79:0] v_lw_a, v_lw_b, v_lw_c, v_lw_d, v_alu;

    initial begin
        rst             = 1'b1;
        stall           = 6'd0;
        ex_to_mem_bus   = '0;
        data_sram_rdata = 32'h0;

        tick();
        push("reset", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        rst           = 1'b0;
        ex_to_mem_bus = mk(c_LW, 32'h400, 1'b1, 1'b1, 5'd5, 32'h1000);

        step(32'hDEADBEEF, "lw", 32'h400, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0,
             mk(c_LB, 32'h404, 1'b1, 1'b1, 5'd6, 32'h1003), 6'd0);
        step(32'h80112233, "lb_b3", 32'h404, 1'b1, 5'd6, 32'hFFFFFF80, 1'b0,
             mk(c_LBU, 32'h408, 1'b1, 1'b1, 5'd7, 32'h1003), 6'd0);
        step(32'h80112233, "lbu_b3", 32'h408, 1'b1, 5'd7, 32'h00000080, 1'b0,
             mk(c_LH, 32'h40C, 1'b1, 1'b1, 5'd8, 32'h1002), 6'd0);
        step(32'h80112233, "lh_h1", 32'h40C, 1'b1, 5'd8, 32'hFFFF8011, 1'b0,
             mk(c_LHU, 32'h410, 1'b1, 1'b1, 5'd10, 32'h1002), 6'd0);
        step(32'h80112233, "lhu_h1", 32'h410, 1'b1, 5'd10, 32'h00008011, 1'b0,
             mk(c_LB, 32'h414, 1'b1, 1'b1, 5'd11, 32'h1000), 6'd0);
        step(32'h80112233, "lb_b0", 32'h414, 1'b1, 5'd11, 32'h00000033, 1'b0,
             mk(c_LH, 32'h418, 1'b1, 1'b1, 5'd12, 32'h1000), 6'd0);
        step(32'h80112233, "lh_h0", 32'h418, 1'b1, 5'd12, 32'h00002233, 1'b0,
             mk(c_SB, 32'h41C, 1'b0, 1'b0, 5'd0, 32'h2000), 6'd0);
        step(32'h80112233, "store", 32'h41C, 1'b0, 5'd0, 32'h00002000, 1'b0,
             mk(4'b0000, 32'h420, 1'b0, 1'b1, 5'd9, 32'h2A), 6'd0);
        v_alu = mk(4'b0000, 32'h420, 1'b0, 1'b1, 5'd9, 32'h2A);
        step(32'h55555555, "alu", 32'h420, 1'b1, 5'd9, 32'h0000002A, 1'b0, v_alu, 6'd0);

        async_reset_pulse("async_rst");

        v_lw_a = mk(c_LW, 32'h428, 1'b1, 1'b1, 5'd14, 32'h1100);
        step(32'h55555555, "alu_after_rst", 32'h420, 1'b1, 5'd9, 32'h0000002A, 1'b0,
             mk(c_LW, 32'h424, 1'b1, 1'b1, 5'd13, 32'h1002), 6'd0);
        step(32'hCAFEF00D, "lw_misalign", 32'h424, c_MIS_WE, 5'd13, 32'hCAFEF00D, c_MIS_ALE,
             v_lw_a, 6'd0);

        // Freeze MEM for three edges; SRAM word changes after the first.
        step(32'h11111111, "hold_enter", 32'h428, 1'b1, 5'd14, 32'h11111111, 1'b0,
             v_lw_a, 6'b011000);
        step(32'h22222222, "hold_1", 32'h428, 1'b1, 5'd14, 32'h11111111, 1'b0,
             v_lw_a, 6'b011000);
        step(32'h22222222, "hold_2", 32'h428, 1'b1, 5'd14, 32'h11111111, 1'b0,
             v_lw_a, 6'b011000);
        step(32'h22222222, "hold_3", 32'h428, 1'b1, 5'd14, 32'h11111111, 1'b0,
             v_lw_a, 6'd0);
        v_lw_b = mk(c_LW, 32'h42C, 1'b1, 1'b1, 5'd15, 32'h1200);
        step(32'h22222222, "hold_release", 32'h428, 1'b1, 5'd14, 32'h22222222, 1'b0,
             v_lw_b, 6'd0);

        // Bubble insertion, then the bubble held.
        step(32'h12345678, "pre_bubble", 32'h42C, 1'b1, 5'd15, 32'h12345678, 1'b0,
             mk(c_LW, 32'h5000, 1'b1, 1'b1, 5'd20, 32'h1300), 6'b001000);
        v_lw_c = mk(c_LW, 32'h430, 1'b1, 1'b1, 5'd16, 32'h1300);
        step(32'h12345678, "bubble", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
             mk(c_LW, 32'h5000, 1'b1, 1'b1, 5'd20, 32'h1300), 6'b011000);
        step(32'h12345678, "bubble_held", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, v_lw_c, 6'd0);

        // Enter HELD, then reset mid-hold; afterwards the live SRAM word must be used.
        step(32'hAAAA0000, "held_pre_rst", 32'h430, 1'b1, 5'd16, 32'hAAAA0000, 1'b0,
             v_lw_c, 6'b011000);
        step(32'hBBBB0000, "held_buf", 32'h430, 1'b1, 5'd16, 32'hAAAA0000, 1'b0,
             v_lw_c, 6'b011000);
        async_reset_pulse("rst_mid_held");
        v_lw_d = mk(c_LW, 32'h434, 1'b1, 1'b1, 5'd17, 32'h1400);
        ex_to_mem_bus = v_lw_d;
        stall         = 6'd0;
        step(32'h33333333, "idle_after_rst", 32'h434, 1'b1, 5'd17, 32'h33333333, 1'b0,
             80'd0, 6'd0);
        step(32'h0, "final_empty", 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 80'd0, 6'd0);

        tick();
        tick();
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
